// File: rtl/tap_clk_ctl_apb_if.sv
// APB3 bus bundle for the TAP clock control register block.
interface tap_clk_ctl_apb_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/tap_clk_ctl_apb.sv
// APB3 register block owning the TAP clock control word, with a glitch-safe gate/switch/settle
// sequence for divider changes. Optional sticky lock bit [31] enabled by TAP_CTL_LOCK_EN.
module tap_clk_ctl_apb #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned GATE_CYCLES = 120
) (
    input  logic                    CRCU_CLK,
    input  logic                    CRCU_RST_N,
    tap_clk_ctl_apb_if.slave        apb,
    output logic [31:0]             tap_clock_ctl_reg,
    output logic                    switch_busy
);
    localparam int unsigned CNT_W = $clog2(GATE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GATE_CYCLES - 1);

    if (GATE_CYCLES < 1) begin : g_param_check
        $error("GATE_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        StIdle,
        StGateWait,
        StApply,
        StSettleWait
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        out_q, out_d;     // active word driven to the generator
    logic [4:0]        shadow_q, shadow_d;
    logic              lock_bit;

    logic [ADDR_W-1:0] paddr;
    logic              access;
    logic              is_ctl;
    logic              is_status;
    logic [2:0]        wr_sel;
    logic              ctl_wr_err;
    logic              wr_err;
    logic              ctl_we;
    logic              unused_bits;

    assign paddr       = apb.PADDR;
    assign access      = apb.PSEL & apb.PENABLE;
    assign is_ctl      = (paddr[3:2] == 2'b00);
    assign is_status   = (paddr[3:2] == 2'b01);
    assign wr_sel      = apb.PWDATA[2:0];
    assign switch_busy = (state_q != StIdle);

`ifdef TAP_CTL_LOCK_EN
    logic lock_q, lock_d;
    assign lock_bit = lock_q;
`else
    assign lock_bit = 1'b0;
`endif

    assign ctl_wr_err  = (wr_sel > 3'd4) | switch_busy | lock_bit;
    assign wr_err      = is_ctl ? ctl_wr_err : 1'b1;
    assign ctl_we      = access & apb.PWRITE & is_ctl & ~ctl_wr_err;
    assign unused_bits = ^{apb.PADDR, apb.PWDATA};

    assign apb.PREADY      = 1'b1;
    assign apb.PSLVERR     = access & apb.PWRITE & wr_err;
    assign tap_clock_ctl_reg = {lock_bit, 26'd0, out_q};

    always_comb begin
        apb.PRDATA = 32'd0;
        if (access && !apb.PWRITE) begin
            if (is_ctl) begin
                apb.PRDATA = {lock_bit, 26'd0, shadow_q};
            end else if (is_status) begin
                apb.PRDATA = {25'd0, out_q[2:0], 3'd0, switch_busy};
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        shadow_d = shadow_q;
`ifdef TAP_CTL_LOCK_EN
        lock_d   = lock_q | (ctl_we & apb.PWDATA[31]);
`endif
        unique case (state_q)
            StIdle: begin
                if (ctl_we) begin
                    shadow_d = apb.PWDATA[4:0];
                    // Divider may only change freely when the TAP clock is not live.
                    if (wr_sel == out_q[2:0] || !out_q[3] || out_q[4]) begin
                        out_d = apb.PWDATA[4:0];
                    end else begin
                        out_d[4] = 1'b1;
                        cnt_d    = CNT_LOAD;
                        state_d  = StGateWait;
                    end
                end
            end
            StGateWait: begin
                if (cnt_q == '0) begin
                    out_d[2:0] = shadow_q[2:0];
                    state_d    = StApply;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StApply: begin
                cnt_d   = CNT_LOAD;
                state_d = StSettleWait;
            end
            StSettleWait: begin
                if (cnt_q == '0) begin
                    out_d[4:3] = shadow_q[4:3];
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CRCU_CLK or negedge CRCU_RST_N) begin
        if (!CRCU_RST_N) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            out_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            shadow_q <= shadow_d;
        end
    end

`ifdef TAP_CTL_LOCK_EN
    always_ff @(posedge CRCU_CLK or negedge CRCU_RST_N) begin
        if (!CRCU_RST_N) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

endmodule
